// File: rtl/width_conv_pkg.sv
// Shared constants and helpers for the width-converting FIFO.
// Lane count and lane ordering are computed here so all users agree.
package width_conv_pkg;

  localparam int WR_WIDTH_DEF = 32;
  localparam int RD_WIDTH_DEF = 8;
  localparam int DEPTH_DEF    = 512;

  function automatic int lanes_of(input int wr, input int rd);
    return wr / rd;
  endfunction

  function automatic int lane_sel(
    input int idx,
    input bit big_endian,
    input int ratio
  );
    return big_endian ? ratio - 1 - idx : idx;
  endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port RAM, one write port, one read port.
// Read data is registered; a synchronous clear empties the read register.
module sdp_ram_1clk #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // storage write
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read, cleared together with the FIFO
  always_ff @(posedge clk) begin
    if (i_clr)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/width_conv_fifo.sv
// Width-converting FIFO: wide words in, narrow lanes out.
// The RAM read register doubles as the output word register.
module width_conv_fifo
  import width_conv_pkg::*;
#(
  parameter int WR_WIDTH   = WR_WIDTH_DEF,
  parameter int RD_WIDTH   = RD_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int BIG_ENDIAN = 0,
  localparam int RATIO  = lanes_of(WR_WIDTH, RD_WIDTH),
  localparam int LANE_W = $clog2(RATIO),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic                wr_last,
  input  logic [LANE_W-1:0]   wr_lanes,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic                rd_last,
  output logic [PTR_W:0]      fill_words
);

  localparam int DATA_W = WR_WIDTH + 1 + LANE_W;
  localparam logic [PTR_W:0]    FULL_C   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    P_ONE    = (PTR_W+1)'(1);
  localparam logic [LANE_W-1:0] L_ONE    = LANE_W'(1);
  localparam logic [LANE_W-1:0] LANE_MAX = '1;

  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic [LANE_W-1:0]   r_lane;
  logic                r_ovalid;

  logic                w_clr;
  logic                w_wr;
  logic                w_hs;
  logic                w_final;
  logic                w_pop;
  logic                w_fetch;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_olast;
  logic [LANE_W-1:0]   w_olanes;
  logic [WR_WIDTH-1:0] w_word;
  logic [LANE_W-1:0]   w_sel;

  assign w_clr    = rst | flush;
  assign wr_ready = !rst && (r_count < FULL_C);
  assign w_wr     = wr_valid & wr_ready & !flush;

  // non-final words always carry every lane
  assign w_wdata = {wr_last,
                    wr_last ? wr_lanes : LANE_MAX,
                    wr_data};

  assign {w_olast, w_olanes, w_word} = w_rdata;

  assign w_hs    = r_ovalid & rd_ready;
  assign w_final = (r_lane == w_olanes);
  assign w_pop   = w_hs & w_final;

  // refill when empty or when the last lane leaves this cycle
  assign w_fetch = !w_clr
                && (r_wr_ptr != r_rd_ptr)
                && (!r_ovalid || w_pop);

  assign w_sel = LANE_W'(lane_sel(int'(r_lane),
                                  BIG_ENDIAN != 0,
                                  RATIO));

  assign rd_valid   = r_ovalid;
  assign rd_last    = r_ovalid & w_olast & w_final;
  assign rd_data    = w_word[w_sel*RD_WIDTH +: RD_WIDTH];
  assign fill_words = r_count;

  sdp_ram_1clk #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[PTR_W-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_fetch),
    .i_raddr (r_rd_ptr[PTR_W-1:0]),
    .o_rdata (w_rdata)
  );

  // pointers, occupancy and output lane sequencing
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lane   <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (w_wr)    r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_fetch) r_rd_ptr <= r_rd_ptr + P_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + P_ONE;
        2'b01:   r_count <= r_count - P_ONE;
        default: r_count <= r_count;
      endcase
      if (w_fetch) begin
        r_ovalid <= 1'b1;
        r_lane   <= '0;
      end else if (w_pop) begin
        r_ovalid <= 1'b0;
      end else if (w_hs) begin
        r_lane   <= r_lane + L_ONE;
      end
    end
  end

endmodule

// File: tb/tb_width_conv_fifo.sv
// Bench for width_conv_fifo: table vectors, directed corners, random run.
// Reference model keeps whole words in a queue and emits lanes from them.
module tb_width_conv_fifo;

  localparam int DEPTH = 512;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       wr_valid, wr_last, rd_ready;
  logic [31:0] wr_data;
  logic [1:0] wr_lanes;

  logic       wr_ready, rd_valid, rd_last;
  logic [7:0] rd_data;
  logic [9:0] fill_words;
  logic       wr_ready_b, rd_valid_b, rd_last_b;
  logic [7:0] rd_data_b;
  logic [9:0] fill_words_b;

  always #5 clk = ~clk;

  width_conv_fifo #(
    .WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(DEPTH), .BIG_ENDIAN(0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .wr_lanes(wr_lanes),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .fill_words(fill_words)
  );

  width_conv_fifo #(
    .WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(DEPTH), .BIG_ENDIAN(1)
  ) dut_be (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b),
    .wr_data(wr_data), .wr_last(wr_last), .wr_lanes(wr_lanes),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready),
    .rd_data(rd_data_b), .rd_last(rd_last_b),
    .fill_words(fill_words_b)
  );

  typedef struct {
    logic [31:0] d;
    int          n;
    bit          l;
    int          wc;
  } word_t;

  typedef struct {
    bit          wv;
    logic [31:0] wd;
    bit          wl;
    logic [1:0]  wn;
    bit          rr;
    bit          erv;
    logic [7:0]  ed;
    bit          el;
    int          ef;
  } vec_t;

  word_t q[$];
  int    lidx;
  int    cyc;
  int    n_vec;
  int    n_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_valid();
    return q.size() > 0 && cyc >= q[0].wc + 1;
  endfunction

  function automatic logic [7:0] exp_lane(input bit be);
    logic [31:0] t;
    int k;
    k = be ? 3 - lidx : lidx;
    t = q[0].d >> (8 * k);
    return t[7:0];
  endfunction

  // compare both DUTs against the model, then advance one clock
  task automatic tick();
    bit    v, acc, hs, clr, lst;
    word_t w;
    v = exp_valid();
    chk("rd_valid", rd_valid, v);
    chk("rd_valid_be", rd_valid_b, v);
    chk("fill", fill_words, q.size());
    chk("fill_be", fill_words_b, q.size());
    chk("wr_ready", wr_ready, !rst && q.size() < DEPTH);
    chk("wr_ready_be", wr_ready_b, !rst && q.size() < DEPTH);
    if (v) begin
      lst = q[0].l && (lidx == q[0].n - 1);
      chk("rd_data", rd_data, exp_lane(1'b0));
      chk("rd_data_be", rd_data_b, exp_lane(1'b1));
      chk("rd_last", rd_last, lst);
      chk("rd_last_be", rd_last_b, lst);
    end
    acc  = wr_valid && !rst && q.size() < DEPTH;
    hs   = v && rd_ready;
    clr  = rst || flush;
    w.d  = wr_data;
    w.n  = wr_last ? int'(wr_lanes) + 1 : 4;
    w.l  = wr_last;
    @(posedge clk);
    cyc++;
    if (clr) begin
      q.delete();
      lidx = 0;
    end else begin
      if (hs) begin
        lidx++;
        if (lidx == q[0].n) begin
          void'(q.pop_front());
          lidx = 0;
        end
      end
      if (acc) begin
        w.wc = cyc;
        q.push_back(w);
      end
    end
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 10 && !rd_valid; i++) tick();
    chk("wait_valid", rd_valid, 1);
  endtask

  task automatic drain(input int budget);
    wr_valid = 0;
    flush    = 0;
    rd_ready = 1;
    for (int i = 0; i < budget && q.size() != 0; i++) tick();
    tick();
    chk("drain_fill", fill_words, 0);
  endtask

  vec_t       tbl[12];
  logic [7:0] be_exp[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int run, first, last;
    n_vec = 0; n_err = 0; cyc = 0; lidx = 0;
    rst = 1; flush = 0; wr_valid = 0; wr_last = 0;
    wr_data = 0; wr_lanes = 0; rd_ready = 0;

    tbl[0]  = '{1, 32'h44332211, 0, 0, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 32'h0,        0, 0, 1, 0, 8'h00, 0, 1};
    tbl[2]  = '{0, 32'h0,        0, 0, 1, 1, 8'h11, 0, 1};
    tbl[3]  = '{0, 32'h0,        0, 0, 1, 1, 8'h22, 0, 1};
    tbl[4]  = '{0, 32'h0,        0, 0, 1, 1, 8'h33, 0, 1};
    tbl[5]  = '{0, 32'h0,        0, 0, 1, 1, 8'h44, 0, 1};
    tbl[6]  = '{1, 32'hDDCCBBAA, 1, 1, 1, 0, 8'h00, 0, 0};
    tbl[7]  = '{0, 32'h0,        0, 0, 1, 0, 8'h00, 0, 1};
    tbl[8]  = '{0, 32'h0,        0, 0, 1, 1, 8'hAA, 0, 1};
    tbl[9]  = '{0, 32'h0,        0, 0, 1, 1, 8'hBB, 1, 1};
    tbl[10] = '{0, 32'h0,        0, 0, 1, 0, 8'h00, 0, 0};
    tbl[11] = '{0, 32'h0,        0, 0, 1, 0, 8'h00, 0, 0};
    be_exp  = '{8'h44, 8'h33, 8'h22, 8'h11};

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_fill", fill_words, 0);
    chk("reset_rd_data", rd_data, 0);
    tick();
    rst = 0;
    #1;
    chk("wr_ready_after_rst", wr_ready, 1);

    // table: plain word, then short final word
    for (int i = 0; i < 12; i++) begin
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].wd;
      wr_last  = tbl[i].wl;
      wr_lanes = tbl[i].wn;
      rd_ready = tbl[i].rr;
      chk($sformatf("t%0d_rd_valid", i), rd_valid, tbl[i].erv);
      chk($sformatf("t%0d_fill", i), fill_words, tbl[i].ef);
      if (tbl[i].erv) begin
        chk($sformatf("t%0d_rd_data", i), rd_data, tbl[i].ed);
        chk($sformatf("t%0d_rd_last", i), rd_last, tbl[i].el);
      end
      tick();
    end

    // fill to capacity, hold an extra word, free one slot
    rd_ready = 0;
    wr_valid = 1;
    wr_last  = 0;
    for (int i = 0; i < 600 && q.size() < DEPTH; i++) begin
      wr_data = 32'h1000_0000 + i;
      tick();
    end
    chk("full_fill", fill_words, 512);
    chk("full_wr_ready", wr_ready, 0);
    wr_data = 32'hA5A5_0513;
    repeat (3) tick();
    chk("held_fill", fill_words, 512);
    rd_ready = 1;
    repeat (4) tick();
    rd_ready = 0;
    chk("wr_ready_after_pop", wr_ready, 1);
    chk("fill_after_pop", fill_words, 511);
    tick();
    wr_valid = 0;
    chk("held_word_taken", fill_words, 512);
    drain(3000);

    // three queued words stream without bubbles
    rd_ready = 0;
    wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h0A0B0C00 + 32'h01010101 * i;
      tick();
    end
    wr_valid = 0;
    repeat (3) tick();
    rd_ready = 1;
    run = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      if (rd_valid) begin
        run++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
    end
    chk("stream_len", run, 12);
    chk("stream_span", last - first + 1, 12);

    // backpressure on lane 2
    wr_valid = 1;
    wr_data  = 32'h44332211;
    tick();
    wr_valid = 0;
    wait_valid();
    repeat (2) tick();
    rd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", rd_data, 8'h33);
      chk("hold_valid", rd_valid, 1);
      tick();
    end
    rd_ready = 1;
    chk("resume_lane2", rd_data, 8'h33);
    tick();
    chk("resume_lane3", rd_data, 8'h44);
    tick();

    // flush mid-word with a colliding write
    wr_valid = 1;
    wr_data  = 32'h44332211;
    tick();
    wr_valid = 0;
    wait_valid();
    tick();
    flush    = 1;
    wr_valid = 1;
    wr_data  = 32'hBAD0BAD0;
    tick();
    flush    = 0;
    wr_valid = 0;
    chk("flush_rd_valid", rd_valid, 0);
    chk("flush_fill", fill_words, 0);
    chk("flush_wr_ready", wr_ready, 1);
    chk("flush_rd_data", rd_data, 0);
    repeat (4) tick();

    // lane order of the big-endian instance
    wr_valid = 1;
    wr_data  = 32'h44332211;
    tick();
    wr_valid = 0;
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("be_lane%0d", k), rd_data_b, be_exp[k]);
      tick();
    end

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      wr_valid = $urandom_range(0, 99) < 60;
      wr_data  = $urandom;
      wr_last  = $urandom_range(0, 3) == 0;
      wr_lanes = 2'($urandom);
      rd_ready = $urandom_range(0, 99) < 70;
      flush    = $urandom_range(0, 299) == 0;
      tick();
    end
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/width_conv_fifo.md
Name: width_conv_fifo

Overview:
Single-clock FIFO that converts width. It accepts WR_WIDTH-bit words on a valid/ready write port and returns them as RD_WIDTH-bit lanes on a valid/ready read port. It generalises the fixed 32-to-8 packet buffer in width, depth and lane order. It adds flow control, frame-end marking with partial final words, an occupancy count and a synchronous flush. It sits between the MAC-side word writer and the byte-stream AXIS egress.

Parameters:
WR_WIDTH, 32, write word width in bits; must be RD_WIDTH*RATIO.
RD_WIDTH, 8, read lane width in bits.
DEPTH, 512, capacity in write words; power of two, at least 2.
BIG_ENDIAN, 0, 0 = lane 0 is bits [RD_WIDTH-1:0] and is emitted first; 1 = the most-significant lane is emitted first.
Derived: RATIO = WR_WIDTH/RD_WIDTH, a power of two, at least 2. LANE_W = $clog2(RATIO). PTR_W = $clog2(DEPTH).

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
flush  in  1  synchronous clear of all contents.
wr_valid  in  1  write word valid.
wr_ready  out  1  the FIFO can accept a word.
wr_data  in  WR_WIDTH  write word.
wr_last  in  1  this word ends a frame.
wr_lanes  in  LANE_W  number of valid lanes minus 1; honoured only when wr_last=1, otherwise treated as RATIO-1.
rd_valid  out  1  rd_data is valid.
rd_ready  in  1  the consumer accepts the lane.
rd_data  out  RD_WIDTH  current lane.
rd_last  out  1  current lane is the final valid lane of a frame.
fill_words  out  PTR_W+1  number of words held, including the word being read out.

Behaviour:
- Reset and flush act identically:
  - Pointers, count, lane index and the output word register are cleared.
  - rd_valid=0, rd_last=0, rd_data=0, fill_words=0.
  - wr_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.
  - flush takes priority over a write or read handshake in the same cycle; that write is dropped and that read has no effect.
- Write handshake: a word is accepted when wr_valid & wr_ready.
  - wr_ready = !rst & (fill_words < DEPTH).
  - A write while full is not accepted, so the producer holds the word.
  - {wr_last, lane count, wr_data} are stored in RAM at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Fetch: the output word register holds one word.
  - A RAM read is issued when an unfetched word exists and either the output register is empty or its final lane is handshaked this cycle.
  - An unfetched word exists when the write and fetch pointers (PTR_W+1 bits each) differ.
  - RAM read latency is 1 cycle. The output register loads on the following edge and the lane index resets to 0.
- Latency: a word written on edge N is fetched in cycle N+1, and rd_valid=1 with the first lane in cycle N+2.
- Read handshake: each rd_valid & rd_ready advances the lane index.
  - The final lane is lane RATIO-1, or the stored lane count for a word written with wr_last=1.
  - rd_last=1 only on the final lane of a word written with wr_last=1.
  - Lanes after the final lane are skipped and never emitted.
  - Handshaking the final lane pops the word: fill_words decrements and, if no fetch lands, rd_valid drops next cycle.
- Throughput: streaming with rd_ready held at 1 produces no bubbles between words.
- Backpressure: rd_data, rd_last and rd_valid hold stable while rd_valid & !rd_ready.
- Simultaneous write and pop leave fill_words unchanged. wr_ready reflects the count registered at the previous edge, so a pop does not free space combinationally.
- Lane mux: rd_data is taken from the output register at the lane index, or at RATIO-1-index when BIG_ENDIAN=1.
- Read and write in the same cycle never hit the same RAM address, because fetch only targets words committed on an earlier edge.

Decomposition:
- Package width_conv_pkg holds:
  - default width and depth constants;
  - function lanes_of(wr,rd) for RATIO;
  - function lane_sel(idx, big_endian).
- Sub-module sdp_ram_1clk(DATA_W, DEPTH) is a behavioural simple-dual-port RAM with 1-cycle registered read. Metadata (last flag and lane count) is stored as extra RAM bits, DATA_W = WR_WIDTH+1+LANE_W.

Test Plan:
1. Reset, then write 0x44332211 with last=0 and rd_ready=1. Required: rd_valid first in the 2nd cycle after the write; rd_data sequence 0x11, 0x22, 0x33, 0x44; rd_last=0; fill_words returns to 0.
2. Write 0xDDCCBBAA with last=1 and wr_lanes=1. Required: output 0xAA then 0xBB with rd_last=1; lanes 0xCC and 0xDD are never emitted; rd_valid=0 afterwards.
3. Write 512 words with rd_ready=0. Required: fill_words=512 and wr_ready=0; a 513th word is held. Four lane handshakes then follow with no write. Required: wr_ready=1 in the cycle after the 4th handshake.
4. Three words pre-loaded, then rd_ready=1 continuously. Required: 12 consecutive rd_valid cycles with no bubble; lane order matches the input.
5. rd_ready=0 for 5 cycles on lane 2 of 0x44332211. Required: rd_data held at 0x33 throughout. Then rd_ready=1. Required: 0x33, 0x44 follow.
6. flush mid-word, with a simultaneous write. Required next cycle: rd_valid=0, fill_words=0, wr_ready=1; the written word is never read. With BIG_ENDIAN=1, 0x44332211 must read out as 0x44, 0x33, 0x22, 0x11.
